frame_sequencer: RTL

Single-clock controller that sequences a two-level item/set count: N_ITEMS items per set and N_SETS sets per frame. It replaces clock-ORed counter chaining with enable-based counting and adds start/stall/abort/ack handshakes. It drives per-beat indices and valid strobes to the downstream datapath and flags frame completion. Instantiated wherever a frame of N_ITEMS×N_SETS beats must be issued under stall control.

---
 rtl/frame_seq_pkg.sv | 12 +
 rtl/mod_n_en_counter.sv | 19 +
 rtl/frame_sequencer.sv | 51 +++++
 3 files changed

// File: rtl/frame_seq_pkg.sv
// frame_seq_pkg: state encoding and default geometry shared by the frame sequencer.
package frame_seq_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;
  localparam int N_ITEMS_DEF = 6;
  localparam int ITEM_W_DEF  = 3;
  localparam int N_SETS_DEF  = 2;
  localparam int SET_W_DEF   = 1;
endpackage

// File: rtl/mod_n_en_counter.sv
// mod_n_en_counter: enable-driven mod-N counter with synchronous clear and wrap strobe.
module mod_n_en_counter #(
  parameter int N = 6,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         GlobalReset,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         wrap
);
  localparam logic [W-1:0] LAST = W'(N - 1);
  assign wrap = en && cnt == LAST;
  always_ff @(posedge clk or negedge GlobalReset)
    if (!GlobalReset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: issues N_ITEMS x N_SETS beats per frame under start/stall/abort/ack control.
module frame_sequencer
  import frame_seq_pkg::*;
#(
  parameter int N_ITEMS = N_ITEMS_DEF,
  parameter int ITEM_W  = ITEM_W_DEF,
  parameter int N_SETS  = N_SETS_DEF,
  parameter int SET_W   = SET_W_DEF
) (
  input  logic              clk,
  input  logic              GlobalReset,
  input  logic              start,
  input  logic              stall,
  input  logic              abort,
  input  logic              ack,
  output logic [ITEM_W-1:0] item_idx,
  output logic [SET_W-1:0]  set_idx,
  output logic              item_valid,
  output logic              set_end,
  output logic              frame_last,
  output logic              busy,
  output logic              frame_done
);
  state_t state;
  logic run, clr, item_wrap, set_wrap;
  assign run = state == RUN;
  // Indices are held at zero outside RUN so every frame starts from the origin.
  assign clr = !run || abort;
  mod_n_en_counter #(.N(N_ITEMS), .W(ITEM_W)) u_items (
    .clk(clk), .GlobalReset(GlobalReset), .en(run && !stall), .clr(clr),
    .cnt(item_idx), .wrap(item_wrap)
  );
  mod_n_en_counter #(.N(N_SETS), .W(SET_W)) u_sets (
    .clk(clk), .GlobalReset(GlobalReset), .en(item_wrap), .clr(clr),
    .cnt(set_idx), .wrap(set_wrap)
  );
  assign item_valid = run && !stall;
  assign set_end    = item_wrap;
  assign frame_last = set_wrap;
  assign busy       = run;
  assign frame_done = state == DONE;
  always_ff @(posedge clk or negedge GlobalReset)
    if (!GlobalReset) state <= IDLE;
    else
      case (state)
        IDLE: state <= start ? RUN : IDLE;
        RUN:  state <= abort ? IDLE : set_wrap ? DONE : RUN;
        DONE: state <= ack ? (start ? RUN : IDLE) : DONE;
        default: state <= IDLE;
      endcase
endmodule
